toy_fetch_queue: RTL and testbench

- Parametrised instruction-fetch front end for the next-generation RISC toy pipeline. Replaces the single IF latch with a DEPTH-entry prefetch FIFO.
- Owns the PC and issues requests to the synchronous instruction memory, with credit-based flow control.
- Buffers returned instructions together with their word addresses for the decode stage.
- Supports branch/jump redirect with flush and kill of the in-flight request, and decode-side backpressure.

---
 rtl/toy_fetch_queue.sv | 89 ++++++++
 tb/tb_toy_fetch_queue.sv | 138 +++++++++++++
 2 files changed

// File: rtl/toy_fetch_queue.sv
// toy_fetch_queue: PC owner and DEPTH-entry prefetch FIFO with credit-limited fetch and redirect flush.
// Define FETCHQ_STATS_EN to add the saturating FLUSH_CNT output.
module toy_fetch_queue #(
  parameter int IW = 32,
  parameter int AW = 30,
  parameter int DEPTH = 4,
  parameter logic [AW-1:0] RESET_ADDR = '0
) (
  input  logic                     CLK,
  input  logic                     RSTN,
  output logic                     IREQ,
  output logic [AW-1:0]            IADDR,
  input  logic [IW-1:0]            INSTR,
  input  logic                     REDIRECT,
  input  logic [AW-1:0]            REDIRECT_ADDR,
  input  logic                     DEQ,
  output logic                     VALID,
  output logic [IW-1:0]            OUT_INSTR,
  output logic [AW-1:0]            OUT_ADDR,
  output logic [$clog2(DEPTH):0]   LEVEL
`ifdef FETCHQ_STATS_EN
  ,output logic [15:0]             FLUSH_CNT
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [AW-1:0] pc_q, pc_d, tag_q, tag_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic          infl_q, infl_d;
  logic          deq_fire, resp_fire, ireq;
  logic [IW-1:0] ibuf_q [DEPTH];
  logic [AW-1:0] abuf_q [DEPTH];
  always_comb begin
    deq_fire  = DEQ & (cnt_q != '0) & ~REDIRECT;
    resp_fire = infl_q & ~REDIRECT;
    // credit check counts the in-flight response so the FIFO can never overflow
    ireq      = RSTN & ~REDIRECT &
                (({1'b0, cnt_q} + (CW+1)'(infl_q) - (CW+1)'(deq_fire)) < (CW+1)'(DEPTH));
    cnt_d     = REDIRECT ? '0 : cnt_q + CW'(resp_fire) - CW'(deq_fire);
    rd_d      = REDIRECT ? '0 : rd_q + PW'(deq_fire);
    wr_d      = REDIRECT ? '0 : wr_q + PW'(resp_fire);
    pc_d      = REDIRECT ? REDIRECT_ADDR : ireq ? pc_q + AW'(1) : pc_q;
    tag_d     = ireq ? pc_q : tag_q;
    infl_d    = ireq;
  end
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      pc_q   <= RESET_ADDR;
      tag_q  <= '0;
      cnt_q  <= '0;
      rd_q   <= '0;
      wr_q   <= '0;
      infl_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      tag_q  <= tag_d;
      cnt_q  <= cnt_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      infl_q <= infl_d;
    end
  end
  always_ff @(posedge CLK) begin
    if (resp_fire) begin
      ibuf_q[wr_q] <= INSTR;
      abuf_q[wr_q] <= tag_q;
    end
  end
  assign IREQ      = ireq;
  assign IADDR     = pc_q;
  assign VALID     = cnt_q != '0;
  assign LEVEL     = cnt_q;
  assign OUT_INSTR = VALID ? ibuf_q[rd_q] : '0;
  assign OUT_ADDR  = VALID ? abuf_q[rd_q] : '0;
`ifdef FETCHQ_STATS_EN
  logic [15:0] flush_q, flush_d;
  logic [16:0] flush_sum;
  always_comb begin
    flush_sum = {1'b0, flush_q} + 17'(cnt_q) + 17'(infl_q);
    flush_d   = REDIRECT ? (flush_sum[16] ? 16'hFFFF : flush_sum[15:0]) : flush_q;
  end
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) flush_q <= '0;
    else flush_q <= flush_d;
  end
  assign FLUSH_CNT = flush_q;
`endif
endmodule

// File: tb/tb_toy_fetch_queue.sv
// tb_toy_fetch_queue: queue-based reference model of the fetch front end, checked every cycle.
module tb_toy_fetch_queue;
  localparam int IW = 32, AW = 30, DEPTH = 4, LW = $clog2(DEPTH) + 1;
  logic CLK = 0, RSTN = 0, DEQ = 0, REDIRECT = 0;
  logic [AW-1:0] REDIRECT_ADDR = '0;
  logic [IW-1:0] INSTR, OUT_INSTR;
  logic IREQ, VALID;
  logic [AW-1:0] IADDR, OUT_ADDR;
  logic [LW-1:0] LEVEL;
`ifdef FETCHQ_STATS_EN
  logic [15:0] FLUSH_CNT;
`endif
  toy_fetch_queue #(.IW(IW), .AW(AW), .DEPTH(DEPTH), .RESET_ADDR('0)) dut (
    .CLK(CLK), .RSTN(RSTN), .IREQ(IREQ), .IADDR(IADDR), .INSTR(INSTR),
    .REDIRECT(REDIRECT), .REDIRECT_ADDR(REDIRECT_ADDR), .DEQ(DEQ), .VALID(VALID),
    .OUT_INSTR(OUT_INSTR), .OUT_ADDR(OUT_ADDR), .LEVEL(LEVEL)
`ifdef FETCHQ_STATS_EN
    , .FLUSH_CNT(FLUSH_CNT)
`endif
  );
  always #5 CLK = ~CLK;
  logic [AW-1:0] mem_a = '0;
  always @(posedge CLK) if (IREQ) mem_a <= IADDR;
  function automatic logic [IW-1:0] f(input logic [AW-1:0] a);
    return {{(IW-AW){1'b0}}, a} + 32'h1000;
  endfunction
  assign INSTR = f(mem_a);
  logic [AW-1:0] mq[$];
  logic [AW-1:0] m_pc = '0, m_iaddr = '0, s_iaddr;
  bit m_infl = 0;
  logic s_ireq;
  int m_flush = 0, n_cmp = 0, n_bad = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic cmp_all(input bit e_ireq);
    chk("IREQ", IREQ, e_ireq);
    chk("IADDR", IADDR, m_pc);
    chk("VALID", VALID, mq.size() != 0);
    chk("LEVEL", LEVEL, mq.size());
    chk("OUT_ADDR", OUT_ADDR, mq.size() ? mq[0] : '0);
    chk("OUT_INSTR", OUT_INSTR, mq.size() ? f(mq[0]) : '0);
`ifdef FETCHQ_STATS_EN
    chk("FLUSH_CNT", FLUSH_CNT, m_flush);
`endif
  endtask
  task automatic cyc(input bit d, input bit r, input logic [AW-1:0] ra);
    bit dq, ir;
    DEQ = d; REDIRECT = r; REDIRECT_ADDR = ra;
    #1;
    dq = d && mq.size() > 0 && !r;
    ir = RSTN && !r && (mq.size() + int'(m_infl) - int'(dq) < DEPTH);
    cmp_all(ir);
    s_ireq = IREQ; s_iaddr = IADDR;
    @(posedge CLK);
    if (r) begin
      m_flush = (m_flush + mq.size() + int'(m_infl) > 65535) ? 65535 : m_flush + mq.size() + int'(m_infl);
      mq.delete(); m_pc = ra; m_infl = 0;
    end else begin
      if (dq) void'(mq.pop_front());
      if (m_infl) mq.push_back(m_iaddr);
      m_infl = ir;
      if (ir) begin m_iaddr = m_pc; m_pc = m_pc + 1'b1; end
    end
    @(negedge CLK);
  endtask
  task automatic do_reset();
    RSTN = 0;
    #1;
    chk("rst_ireq", IREQ, 0);
    chk("rst_valid", VALID, 0);
    chk("rst_level", LEVEL, 0);
    chk("rst_out_addr", OUT_ADDR, 0);
    mq.delete(); m_pc = '0; m_infl = 0; m_flush = 0;
    @(negedge CLK); @(negedge CLK);
    RSTN = 1;
  endtask
  initial begin
    int nreq;
    DEQ = 1;
    do_reset();
    cyc(1, 0, 0); chk("t1_ireq0", s_ireq, 1); chk("t1_iaddr0", s_iaddr, 0); chk("t1_valid_c1", VALID, 0);
    cyc(1, 0, 0); chk("t1_valid_c2", VALID, 1); chk("t1_out0", OUT_ADDR, 0); chk("t1_instr0", OUT_INSTR, 32'h1000);
    for (int i = 1; i <= 5; i++) begin
      cyc(1, 0, 0);
      chk("t1_iaddr", s_iaddr, i + 1);
      chk("t1_out", OUT_ADDR, i);
      chk("t1_instr", OUT_INSTR, 32'h1000 + i);
    end
    DEQ = 0;
    do_reset();
    nreq = 0;
    repeat (6) begin cyc(0, 0, 0); nreq += int'(s_ireq); end
    chk("t2_nreq", nreq, 4); chk("t2_level4", LEVEL, 4); chk("t2_ireq_off", s_ireq, 0);
    cyc(1, 0, 0); chk("t2_ireq_deq", s_ireq, 1); chk("t2_iaddr4", s_iaddr, 4); chk("t2_level3", LEVEL, 3);
    cyc(0, 0, 0); chk("t2_level4b", LEVEL, 4); chk("t2_ireq_full", s_ireq, 0);
    cyc(0, 1, 30'h100); chk("t3_level0", LEVEL, 0); chk("t3_valid0", VALID, 0);
`ifdef FETCHQ_STATS_EN
    chk("t3_flush4", FLUSH_CNT, 4);
`endif
    cyc(0, 0, 0); chk("t3_ireq", s_ireq, 1); chk("t3_iaddr", s_iaddr, 30'h100); chk("t3_valid_r1", VALID, 0);
    cyc(0, 0, 0); chk("t3_valid_r2", VALID, 1); chk("t3_out", OUT_ADDR, 30'h100);
    cyc(1, 1, 30'h7);
`ifdef FETCHQ_STATS_EN
    chk("t4_flush6", FLUSH_CNT, 6);
`endif
    cyc(1, 0, 0); chk("t4_iaddr7", s_iaddr, 7);
    cyc(1, 1, 30'h200);
`ifdef FETCHQ_STATS_EN
    chk("t4_flush7", FLUSH_CNT, 7);
`endif
    cyc(1, 0, 0); chk("t4_iaddr200", s_iaddr, 30'h200); chk("t4_no7", VALID, 0);
    cyc(1, 0, 0); chk("t4_valid", VALID, 1); chk("t4_out200", OUT_ADDR, 30'h200);
    cyc(1, 1, 30'h3FFFFFFF);
    cyc(1, 0, 0); chk("t5_iaddr_max", s_iaddr, 30'h3FFFFFFF);
    cyc(1, 0, 0); chk("t5_iaddr_0", s_iaddr, 0); chk("t5_out_max", OUT_ADDR, 30'h3FFFFFFF);
    cyc(1, 0, 0); chk("t5_iaddr_1", s_iaddr, 1); chk("t5_out_0", OUT_ADDR, 0);
    cyc(1, 0, 0); chk("t5_out_1", OUT_ADDR, 1);
    for (int i = 0; i < 400; i++) begin
      logic [AW-1:0] ra;
      ra = ($urandom_range(3) == 0) ? AW'(30'h3FFFFFFE + $urandom_range(1)) : AW'($urandom);
      cyc($urandom_range(99) < 70, $urandom_range(99) < 8, ra);
    end
    cyc(0, 1, 30'h50);
    for (int i = 0; i < 10 && !(mq.size() == 3 && m_infl); i++) cyc(0, 0, 0);
    chk("t6_level3", LEVEL, 3);
    do_reset();
    cyc(1, 0, 0); chk("t6_iaddr0", s_iaddr, 0);
    cyc(1, 0, 0); chk("t6_first", OUT_ADDR, 0); chk("t6_instr", OUT_INSTR, 32'h1000);
    cyc(1, 0, 0); chk("t6_next", OUT_ADDR, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
